// File: rtl/ctrl_reg_pkg.sv
// Shared types and constants for the request/confirm capture register.
// Pure declarations; no logic, no latency, no flow control.
package ctrl_reg_pkg;

  localparam int SEG_W  = 7;
  localparam int DATA_W = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_CONFIRM = 2'd1,
    LOADED       = 2'd2
  } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to seven-segment pattern, bit order {g,f,e,d,c,b,a}, active-high.
// Purely combinational, zero latency, no flow control.
module hex_to_7seg
  import ctrl_reg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ctrl_and_register.sv
// Request/confirm-gated byte capture register with registered dual 7-seg display.
// Display updates on the capture edge (one cycle from sampled inputs); no backpressure.
module ctrl_and_register
  import ctrl_reg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              request,
  input  logic              confirm,
  input  logic [DATA_W-1:0] inputData,
  output logic [SEG_W-1:0]  dataP,
  output logic [SEG_W-1:0]  dataQ
);

  state_t            state;
  state_t            state_nxt;
  logic              capture;
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] stored_nxt;
  logic              valid;
  logic              valid_nxt;
  logic [SEG_W-1:0]  seg_hi;
  logic [SEG_W-1:0]  seg_lo;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dropping request in WAIT_CONFIRM wins over a simultaneous confirm.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (request) state_nxt = WAIT_CONFIRM;
      WAIT_CONFIRM: begin
        if (!request)     state_nxt = IDLE;
        else if (confirm) state_nxt = LOADED;
      end
      LOADED:       if (!confirm) state_nxt = request ? WAIT_CONFIRM : IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture = (state == WAIT_CONFIRM) && request && confirm;
  end

  assign stored_nxt = capture ? inputData : stored;
  assign valid_nxt  = valid | capture;

  // Decode the post-edge value so the segments move on the capture edge itself.
  hex_to_7seg u_dec_hi (.hex(stored_nxt[7:4]), .seg(seg_hi));
  hex_to_7seg u_dec_lo (.hex(stored_nxt[3:0]), .seg(seg_lo));

  always_ff @(posedge clock) begin
    if (reset) begin
      stored <= '0;
      valid  <= 1'b0;
      dataP  <= SEG_BLANK;
      dataQ  <= SEG_BLANK;
    end else begin
      stored <= stored_nxt;
      valid  <= valid_nxt;
      dataP  <= valid_nxt ? seg_hi : SEG_BLANK;
      dataQ  <= valid_nxt ? seg_lo : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_ctrl_and_register.sv
// Scoreboard bench for ctrl_and_register: directed scenarios then random traffic.
module tb_ctrl_and_register;

  logic       clock = 1'b0;
  logic       reset;
  logic       request;
  logic       confirm;
  logic [7:0] inputData;
  logic [6:0] dataP;
  logic [6:0] dataQ;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  ctrl_and_register dut (
    .clock     (clock),
    .reset     (reset),
    .request   (request),
    .confirm   (confirm),
    .inputData (inputData),
    .dataP     (dataP),
    .dataQ     (dataQ)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model in terms of observable behaviour:
  //   armed    - request was high at the previous edge (and no reset since)
  //   consumed - a capture already happened during the current confirm-high run
  bit         m_armed;
  bit         m_consumed;
  bit         m_valid;
  logic [7:0] m_stored;

  logic [13:0] exp_q  [$];
  string       name_q [$];

  task automatic step(input bit rst, input bit req, input bit conf,
                      input logic [7:0] d, input string nm);
    bit cap;
    @(negedge clock);
    reset     = rst;
    request   = req;
    confirm   = conf;
    inputData = d;
    if (rst) begin
      m_armed    = 1'b0;
      m_consumed = 1'b0;
      m_valid    = 1'b0;
      m_stored   = 8'h00;
    end else begin
      cap = m_armed && req && conf && !m_consumed;
      if (cap) begin
        m_stored = d;
        m_valid  = 1'b1;
      end
      m_consumed = conf && (m_consumed || cap);
      m_armed    = req;
    end
    exp_q.push_back(m_valid ? {seg_tab[m_stored[7:4]], seg_tab[m_stored[3:0]]} : 14'h0000);
    name_q.push_back(nm);
  endtask

  // Monitor: the display is registered, so every edge presents a fresh output.
  always @(posedge clock) begin
    logic [13:0] e;
    string       n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if ({dataP, dataQ} !== e) begin
        failed++;
        $display("FAIL %s @%0t: dataP/dataQ got %h/%h expected %h/%h",
                 n, $time, dataP, dataQ, e[13:7], e[6:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; request = 1'b0; confirm = 1'b0; inputData = 8'h00;

    step(1, 1, 1, 8'($urandom), "reset0");
    step(1, 1, 1, 8'($urandom), "reset1");
    repeat (3) step(0, 0, 1, 8'($urandom), "idle_hold");

    step(0, 1, 0, 8'h03, "arm");
    step(0, 1, 1, 8'h03, "cap_03");
    step(0, 1, 1, 8'hE3, "held_conf");
    step(0, 1, 1, 8'hE3, "held_conf2");
    step(0, 1, 0, 8'hE3, "conf_low");
    step(0, 1, 1, 8'hE3, "cap_e3");

    step(0, 0, 0, 8'h00, "to_idle");
    step(0, 1, 1, 8'h83, "same_cycle_arm");
    step(0, 1, 1, 8'h83, "cap_83");

    step(0, 1, 0, 8'h83, "loaded_to_wait");
    step(0, 0, 1, 8'h55, "drop_req_wins");
    step(0, 1, 1, 8'h55, "rearm_no_cap");
    step(0, 0, 0, 8'h55, "idle_again");
    step(0, 1, 0, 8'h83, "arm2");
    step(0, 1, 1, 8'h83, "cap_83b");

    step(1, 1, 1, 8'h99, "reset_loaded");
    step(0, 1, 0, 8'hA5, "arm_a5");
    step(0, 1, 1, 8'hA5, "cap_a5");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           8'($urandom), "random");
    end

    step(0, 0, 0, 8'h00, "drain");
    repeat (3) @(negedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
